// File: rtl/ctrl_pkg.sv
// Shared state encoding, opcode values and datapath select encodings for the multi-cycle control FSM.
// Pure declarations; no latency.
// No flow control.
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD,
        WB_MEM, MEM_WR, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_ALU     = 2'd0;
    localparam logic [1:0] PC_ALUOUT  = 2'd1;

    localparam logic [1:0] A_PC       = 2'd0;
    localparam logic [1:0] A_OLDPC    = 2'd1;
    localparam logic [1:0] A_RS1      = 2'd2;

    localparam logic [1:0] B_RS2      = 2'd0;
    localparam logic [1:0] B_IMM      = 2'd1;
    localparam logic [1:0] B_FOUR     = 2'd2;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_SUB    = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;

    localparam logic [1:0] WBS_ALUOUT = 2'd0;
    localparam logic [1:0] WBS_MEM    = 2'd1;
    localparam logic [1:0] WBS_PC     = 2'd2;
    localparam logic [1:0] WBS_IMM    = 2'd3;

    function automatic state_t decode_next(input logic [6:0] opc);
        case (opc)
            OPC_R:               return EXEC_R;
            OPC_I:               return EXEC_I;
            OPC_LOAD, OPC_STORE: return MEM_ADDR;
            OPC_BRANCH:          return BRANCH;
            OPC_JAL:             return JAL;
            OPC_JALR:            return JALR;
            OPC_LUI:             return LUI;
            OPC_AUIPC:           return AUIPC;
            default:             return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: funct3 plus ALU compare flags to taken / illegal.
// Purely combinational, zero latency.
// No flow control.
module branch_cond (
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    output logic       taken_o,
    output logic       illegal_o
);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            3'b000:  taken_o = zero_i;
            3'b001:  taken_o = !zero_i;
            3'b100:  taken_o = lt_i;
            3'b101:  taken_o = !lt_i;
            3'b110:  taken_o = ltu_i;
            3'b111:  taken_o = !ltu_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and counts retired instructions.
// Moore outputs from current state (fetch ack and branch redirect are Mealy); 3-5 cycles per instruction plus memory wait.
// Memory requests hold until ack; a wait longer than WAIT_LIMIT cycles traps (WAIT_LIMIT=0 waits forever).
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_ltu,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_o
);

    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1) + 1;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    instret_q, instret_d;
    logic                br_taken, br_illegal;
    logic                waiting, timeout, retire;

    branch_cond u_branch_cond (
        .funct3_i  (funct3),
        .zero_i    (alu_zero),
        .lt_i      (alu_lt),
        .ltu_i     (alu_ltu),
        .taken_o   (br_taken),
        .illegal_o (br_illegal)
    );

    // Last permitted wait cycle: a miss here means WAIT_LIMIT cycles without ack.
    assign timeout = (WAIT_LIMIT != 0) && (int'(wcnt_q) == WAIT_LIMIT - 1);

    always_comb begin
        state_d   = state_q;
        waiting   = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_ALU;
        alu_a_sel = A_PC;
        alu_b_sel = B_RS2;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        wb_sel    = WBS_ALUOUT;
        halted    = 1'b0;
        case (state_q)
            IDLE: if (run) state_d = FETCH;
            FETCH: begin
                imem_req  = 1'b1;
                alu_a_sel = A_PC;
                alu_b_sel = B_FOUR;
                alu_op    = ALU_ADD;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = PC_ALU;
                    state_d = DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            DECODE: begin
                alu_a_sel = A_OLDPC;
                alu_b_sel = B_IMM;
                alu_op    = ALU_ADD;
                state_d   = decode_next(opcode);
            end
            EXEC_R: begin
                alu_a_sel = A_RS1;
                alu_b_sel = B_RS2;
                alu_op    = ALU_FUNCT;
                state_d   = WB_ALU;
            end
            EXEC_I: begin
                alu_a_sel = A_RS1;
                alu_b_sel = B_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = WB_ALU;
            end
            WB_ALU: begin
                reg_we  = 1'b1;
                wb_sel  = WBS_ALUOUT;
                state_d = FETCH;
            end
            MEM_ADDR: begin
                alu_a_sel = A_RS1;
                alu_b_sel = B_IMM;
                alu_op    = ALU_ADD;
                state_d   = (opcode == OPC_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_d = WB_MEM;
                else          waiting = 1'b1;
            end
            WB_MEM: begin
                reg_we  = 1'b1;
                wb_sel  = WBS_MEM;
                state_d = FETCH;
            end
            MEM_WR: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
                if (dmem_ack) state_d = FETCH;
                else          waiting = 1'b1;
            end
            BRANCH: begin
                alu_a_sel = A_RS1;
                alu_b_sel = B_RS2;
                alu_op    = ALU_SUB;
                if (br_illegal) begin
                    state_d = TRAP;
                end else begin
                    if (br_taken) begin
                        pc_we  = 1'b1;
                        pc_src = PC_ALUOUT;
                    end
                    state_d = FETCH;
                end
            end
            JAL: begin
                reg_we  = 1'b1;
                wb_sel  = WBS_PC;
                pc_we   = 1'b1;
                pc_src  = PC_ALUOUT;
                state_d = FETCH;
            end
            JALR: begin
                alu_a_sel = A_RS1;
                alu_b_sel = B_IMM;
                alu_op    = ALU_ADD;
                pc_we     = 1'b1;
                pc_src    = PC_ALU;
                reg_we    = 1'b1;
                wb_sel    = WBS_PC;
                state_d   = FETCH;
            end
            LUI: begin
                reg_we  = 1'b1;
                wb_sel  = WBS_IMM;
                state_d = FETCH;
            end
            AUIPC: begin
                reg_we  = 1'b1;
                wb_sel  = WBS_ALUOUT;
                state_d = FETCH;
            end
            TRAP:    halted  = 1'b1;
            default: state_d = TRAP;
        endcase
        if (waiting && timeout) state_d = TRAP;
    end

    // Any state change clears the wait counter, so every new request starts from zero.
    assign wcnt_d    = (waiting && state_d == state_q) ? wcnt_q + 1'b1 : '0;
    assign retire    = (state_d == FETCH) && (state_q != IDLE) && (state_q != FETCH);
    assign instret_d = retire ? instret_q + 1'b1 : instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected state/outputs/instret are queued as stimulus is driven
// and compared 2 ns after each falling edge; a second instance with WAIT_LIMIT=0 checks the disabled timeout.
module tb_multicycle_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                           S_MEM_ADDR = 4'd6, S_MEM_RD = 4'd7, S_WB_MEM = 4'd8, S_MEM_WR = 4'd9,
                           S_BRANCH = 4'd10, S_JAL = 4'd11, S_WB_ALU = 4'd5, S_TRAP = 4'd15;

    // {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, a_sel, b_sel, alu_op, reg_we, wb_sel, halted}
    localparam logic [16:0] V_IDLE      = '0;
    localparam logic [16:0] V_FETCH     = {5'b10000, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [16:0] V_FETCH_ACK = {5'b10011, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [16:0] V_DECODE    = {5'b00000, 2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [16:0] V_EXEC_R    = {5'b00000, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0};
    localparam logic [16:0] V_WB_ALU    = {5'b00000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0};
    localparam logic [16:0] V_MEM_ADDR  = {5'b00000, 2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [16:0] V_MEM_RD    = {5'b01000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [16:0] V_WB_MEM    = {5'b00000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 1'b0};
    localparam logic [16:0] V_MEM_WR    = {5'b01100, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [16:0] V_BR        = {5'b00000, 2'd0, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0};
    localparam logic [16:0] V_BR_TAKEN  = {5'b00001, 2'd1, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0};
    localparam logic [16:0] V_JAL       = {5'b00001, 2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0};
    localparam logic [16:0] V_TRAP      = {5'b00000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n, run, imem_ack, dmem_ack, alu_zero, alu_lt, alu_ltu;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, halted;
    logic [1:0]  pc_src, alu_a_sel, alu_b_sel, alu_op, wb_sel;
    logic [31:0] instret;
    logic [3:0]  state_o;

    logic        rst2_n, run2, no_ack;
    logic        imem_req2, dmem_req2, dmem_we2, ir_we2, pc_we2, reg_we2, halted2;
    logic [1:0]  pc_src2, alu_a_sel2, alu_b_sel2, alu_op2, wb_sel2;
    logic [31:0] instret2;
    logic [3:0]  state2;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_LIMIT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we),
        .wb_sel(wb_sel), .halted(halted), .instret(instret), .state_o(state_o)
    );

    multicycle_ctrl #(.WAIT_LIMIT(0), .CNT_W(32)) dut_nolimit (
        .clk(clk), .rst_n(rst2_n), .run(run2), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .imem_req(imem_req2), .imem_ack(no_ack), .dmem_req(dmem_req2), .dmem_we(dmem_we2),
        .dmem_ack(no_ack), .ir_we(ir_we2), .pc_we(pc_we2), .pc_src(pc_src2),
        .alu_a_sel(alu_a_sel2), .alu_b_sel(alu_b_sel2), .alu_op(alu_op2), .reg_we(reg_we2),
        .wb_sel(wb_sel2), .halted(halted2), .instret(instret2), .state_o(state2)
    );

    wire [16:0] outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
                        alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, halted};

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [16:0] v;
        logic [31:0] ir;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    endtask

    // One cycle: drive acks, queue the expectation for this cycle, then advance to the next falling edge.
    task automatic cyc(input string tag, input logic ia, input logic da,
                       input logic [3:0] st, input logic [16:0] v, input logic [31:0] ir);
        exp_t e;
        imem_ack = ia;
        dmem_ack = da;
        e.tag = tag; e.st = st; e.v = v; e.ir = ir;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic restart(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        cyc(tag, 1'b0, 1'b0, S_IDLE, V_IDLE, 0);
        run   = 1'b0;
    endtask

    task automatic do_branch(input string tag, input logic [2:0] f3, input logic z, input logic l,
                             input logic lu, input logic taken, input logic [31:0] ir);
        opcode = 7'b1100011; funct3 = f3; alu_zero = z; alu_lt = l; alu_ltu = lu;
        cyc({tag, "_fetch"}, 1'b1, 1'b0, S_FETCH, V_FETCH_ACK, ir);
        cyc({tag, "_dec"}, 1'b0, 1'b0, S_DECODE, V_DECODE, ir);
        cyc({tag, "_br"}, 1'b0, 1'b0, S_BRANCH, taken ? V_BR_TAKEN : V_BR, ir);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq({e.tag, "/state"}, {28'd0, state_o}, {28'd0, e.st});
                check_eq({e.tag, "/outs"}, {15'd0, outs}, {15'd0, e.v});
                check_eq({e.tag, "/instret"}, instret, e.ir);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0; rst2_n = 1'b0; run = 1'b0; run2 = 1'b0; no_ack = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; opcode = '0; funct3 = '0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; rst2_n = 1'b1; run2 = 1'b1;
        cyc("idle", 1'b0, 1'b0, S_IDLE, V_IDLE, 0);
        run2 = 1'b0;
        run  = 1'b1;
        cyc("idle_run", 1'b0, 1'b0, S_IDLE, V_IDLE, 0);
        run  = 1'b0;

        opcode = 7'b0110011;
        cyc("r_fetch", 1'b1, 1'b0, S_FETCH, V_FETCH_ACK, 0);
        cyc("r_dec", 1'b0, 1'b0, S_DECODE, V_DECODE, 0);
        cyc("r_exec", 1'b0, 1'b0, S_EXEC_R, V_EXEC_R, 0);
        cyc("r_wb", 1'b0, 1'b0, S_WB_ALU, V_WB_ALU, 0);
        cyc("pre_rst_fetch", 1'b0, 1'b0, S_FETCH, V_FETCH, 1);

        // Asynchronous reset in the middle of a FETCH cycle with imem_req high.
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_rst/state", {28'd0, state_o}, 32'd0);
        check_eq("async_rst/outs", {15'd0, outs}, 32'd0);
        check_eq("async_rst/instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        cyc("rst_idle", 1'b0, 1'b0, S_IDLE, V_IDLE, 0);
        run   = 1'b0;

        opcode = 7'b0000011;
        cyc("ld_fetch", 1'b1, 1'b0, S_FETCH, V_FETCH_ACK, 0);
        cyc("ld_dec", 1'b0, 1'b0, S_DECODE, V_DECODE, 0);
        cyc("ld_addr", 1'b0, 1'b0, S_MEM_ADDR, V_MEM_ADDR, 0);
        for (int i = 0; i < 3; i++) cyc("ld_wait", 1'b0, 1'b0, S_MEM_RD, V_MEM_RD, 0);
        cyc("ld_ack", 1'b0, 1'b1, S_MEM_RD, V_MEM_RD, 0);
        cyc("ld_wb", 1'b0, 1'b0, S_WB_MEM, V_WB_MEM, 0);

        // Stray acks while the matching request is low must be ignored.
        opcode = 7'b0100011;
        cyc("st_fetch", 1'b1, 1'b1, S_FETCH, V_FETCH_ACK, 1);
        cyc("st_dec", 1'b1, 1'b1, S_DECODE, V_DECODE, 1);
        cyc("st_addr", 1'b0, 1'b1, S_MEM_ADDR, V_MEM_ADDR, 1);
        cyc("st_wr", 1'b0, 1'b1, S_MEM_WR, V_MEM_WR, 1);

        opcode = 7'b1101111;
        cyc("jal_fetch", 1'b1, 1'b0, S_FETCH, V_FETCH_ACK, 2);
        cyc("jal_dec", 1'b0, 1'b0, S_DECODE, V_DECODE, 2);
        cyc("jal", 1'b0, 1'b0, S_JAL, V_JAL, 2);

        do_branch("beq_t", 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 3);
        do_branch("beq_nt", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        do_branch("bltu_t", 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        do_branch("bge_nt", 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 6);
        do_branch("bne_t", 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 7);
        do_branch("b010", 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        cyc("b010_trap", 1'b1, 1'b0, S_TRAP, V_TRAP, 8);
        cyc("b010_trap_ack", 1'b1, 1'b1, S_TRAP, V_TRAP, 8);

        restart("rst_after_br_trap");
        opcode = 7'b0000000;
        cyc("ill_fetch", 1'b1, 1'b0, S_FETCH, V_FETCH_ACK, 0);
        cyc("ill_dec", 1'b0, 1'b0, S_DECODE, V_DECODE, 0);
        cyc("ill_trap", 1'b1, 1'b0, S_TRAP, V_TRAP, 0);
        cyc("ill_trap_ack", 1'b1, 1'b0, S_TRAP, V_TRAP, 0);

        restart("rst_after_ill");
        for (int i = 0; i < 16; i++) cyc("to_fetch", 1'b0, 1'b0, S_FETCH, V_FETCH, 0);
        cyc("to_trap", 1'b0, 1'b0, S_TRAP, V_TRAP, 0);
        cyc("to_trap_ack", 1'b1, 1'b0, S_TRAP, V_TRAP, 0);

        #3;
        check_eq("nolimit/state", {28'd0, state2}, {28'd0, S_FETCH});
        check_eq("nolimit/imem_req", {31'd0, imem_req2}, 32'd1);
        check_eq("nolimit/halted", {31'd0, halted2}, 32'd0);
        check_eq("nolimit/instret", instret2, 32'd0);
        check_eq("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
